// File: rtl/pgm_rd_mt.sv
// pgm_rd_mt: multi-template packet generator read engine.
// Replays RAM templates round-robin with probes, gap, limit and bypass.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/_wr         bypass packet words (134b, [133:132] 01/11/10)
//   in_phv/_wr          bypass PHV
//   in_alf              downstream almost-full (checked before a packet)
//   out_data/_wr/valid  packet words, valid on tail
//   out_phv/_wr         PHV, zero in generate mode, strobed with head
//   ram_rd/addr/rdata   PGM RAM port, read data one cycle after ram_rd
//   cfg_*               mode, start/stop pulses, mask, gap, probe rate, limit
//   sent_pkt/byte_cnt   64-bit emitted packet and byte counters
//   busy, done          state != IDLE, generation finished
//   err_no_tail         sticky, segment ended without a tail word
module pgm_rd_mt #(
  parameter int NUM_TPL = 4,
  parameter int SEG_W   = 7,
  parameter int PHV_W   = 1024,
  localparam int TW     = (NUM_TPL > 2) ? $clog2(NUM_TPL) : 1,
  localparam int AW     = TW + SEG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [133:0]       in_data,
  input  logic               in_data_wr,
  input  logic [PHV_W-1:0]   in_phv,
  input  logic               in_phv_wr,
  input  logic               in_alf,
  output logic [133:0]       out_data,
  output logic               out_data_wr,
  output logic               out_valid,
  output logic [PHV_W-1:0]   out_phv,
  output logic               out_phv_wr,
  output logic               ram_rd,
  output logic [AW-1:0]      ram_addr,
  input  logic [133:0]       ram_rdata,
  input  logic               cfg_bypass,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [NUM_TPL-2:0] cfg_tpl_mask,
  input  logic [31:0]        cfg_gap,
  input  logic [31:0]        cfg_probe_every,
  input  logic [63:0]        cfg_pkt_limit,
  output logic [63:0]        sent_pkt_cnt,
  output logic [63:0]        sent_byte_cnt,
  output logic               busy,
  output logic               done,
  output logic               err_no_tail
);

  localparam int ND = NUM_TPL - 1;
  localparam logic [TW-1:0] PROBE = TW'(NUM_TPL - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BYP  = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]       r_state;
  logic [TW-1:0]    r_tpl;
  logic             r_probe;
  logic [TW-1:0]    r_ptr;
  logic [SEG_W-1:0] r_ridx;
  logic [31:0]      r_gap_cnt;
  logic [31:0]      r_dsp;
  logic [63:0]      r_data_cnt;
  logic             r_stop_pend;
  logic             r_done;
  logic             r_err;
  logic [63:0]      r_pkt;
  logic [63:0]      r_byte;
  logic [133:0]     r_out_data;
  logic             r_out_wr;
  logic             r_out_valid;
  logic [PHV_W-1:0] r_out_phv;
  logic             r_out_phv_wr;

  logic             w_sel_probe;
  logic [TW-1:0]    w_dsel;
  logic             w_found;
  logic [TW-1:0]    w_sel;
  logic [TW-1:0]    w_ptr_nxt;
  logic [1:0]       w_hdr;
  logic             w_is_tail;
  logic             w_trunc;
  logic             w_last;
  logic [133:0]     w_word;
  logic [63:0]      w_bytes;
  logic             w_data_tail;
  logic [63:0]      w_data_nxt;
  logic             w_end_gen;

  // Round-robin search: first enabled data template at or after r_ptr.
  always_comb begin
    int v_idx;
    logic [TW-1:0] v_i;
    w_dsel  = r_ptr;
    w_found = 1'b0;
    for (int k = 0; k < ND; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= ND) v_idx = v_idx - ND;
      v_i = TW'(v_idx);
      if (!w_found && cfg_tpl_mask[v_i]) begin
        w_found = 1'b1;
        w_dsel  = v_i;
      end
    end
  end

  assign w_sel_probe = (cfg_probe_every != 32'd0 &&
                        r_dsp == cfg_probe_every) ||
                       (cfg_tpl_mask == '0);
  assign w_sel     = w_sel_probe ? PROBE : w_dsel;
  assign w_ptr_nxt = (w_dsel == TW'(ND - 1)) ? '0 : w_dsel + 1'b1;

  assign w_hdr     = ram_rdata[133:132];
  assign w_is_tail = (w_hdr == 2'b10);
  // Segment end without a tail: close the packet ourselves.
  assign w_trunc   = (&r_ridx) && !w_is_tail;
  assign w_last    = w_is_tail || (&r_ridx);
  assign w_word    = w_trunc ? {2'b10, ram_rdata[131:0]} : ram_rdata;
  assign w_bytes   = w_last ?
                     64'(5'd16 - {1'b0, w_word[131:128]}) : 64'd16;

  assign w_data_tail = w_last && !r_probe;
  assign w_data_nxt  = r_data_cnt + {63'd0, w_data_tail};
  assign w_end_gen   = r_stop_pend || cfg_stop ||
                       (cfg_pkt_limit != 64'd0 &&
                        w_data_nxt == cfg_pkt_limit);

  always_comb begin
    ram_rd   = 1'b0;
    ram_addr = '0;
    if (r_state == S_ARM) begin
      ram_rd   = !in_alf;
      ram_addr = {w_sel, {SEG_W{1'b0}}};
    end else if (r_state == S_EMIT) begin
      ram_rd   = !w_last;
      ram_addr = {r_tpl, r_ridx + 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tpl        <= '0;
      r_probe      <= 1'b0;
      r_ptr        <= '0;
      r_ridx       <= '0;
      r_gap_cnt    <= '0;
      r_dsp        <= '0;
      r_data_cnt   <= '0;
      r_stop_pend  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_pkt        <= '0;
      r_byte       <= '0;
      r_out_data   <= '0;
      r_out_wr     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_phv    <= '0;
      r_out_phv_wr <= 1'b0;
    end else begin
      r_out_wr     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_phv_wr <= 1'b0;
      r_out_phv    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (cfg_bypass) begin
            r_state <= S_BYP;
          end else if (cfg_start && !cfg_stop) begin
            r_state     <= S_ARM;
            r_pkt       <= '0;
            r_byte      <= '0;
            r_data_cnt  <= '0;
            r_dsp       <= '0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
          end
        end
        S_BYP: begin
          r_out_data   <= in_data;
          r_out_wr     <= in_data_wr;
          r_out_valid  <= in_data_wr &&
                          in_data[133:132] == 2'b10;
          r_out_phv    <= in_phv;
          r_out_phv_wr <= in_phv_wr;
          if (in_data_wr && in_data[133:132] == 2'b10 &&
              !cfg_bypass)
            r_state <= S_IDLE;
        end
        S_ARM: begin
          if (cfg_stop) r_stop_pend <= 1'b1;
          if (!in_alf) begin
            r_tpl   <= w_sel;
            r_probe <= w_sel_probe;
            if (!w_sel_probe) r_ptr <= w_ptr_nxt;
            r_ridx  <= '0;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          r_out_data   <= w_word;
          r_out_wr     <= 1'b1;
          r_out_phv_wr <= (w_hdr == 2'b01);
          r_ridx       <= r_ridx + 1'b1;
          r_byte       <= r_byte + w_bytes;
          if (cfg_stop) r_stop_pend <= 1'b1;
          if (w_trunc) r_err <= 1'b1;
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_pkt       <= r_pkt + 64'd1;
            r_data_cnt  <= w_data_nxt;
            r_dsp       <= r_probe ? 32'd0 : r_dsp + 32'd1;
            if (w_end_gen) begin
              r_state     <= S_IDLE;
              r_done      <= 1'b1;
              r_stop_pend <= 1'b0;
            end else if (cfg_gap > 32'd1) begin
              r_state   <= S_GAP;
              r_gap_cnt <= 32'd1;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_GAP: begin
          // The ARM cycle is the last idle cycle of the gap.
          if (cfg_stop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (r_gap_cnt >= cfg_gap - 32'd1) begin
            r_state <= S_ARM;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data      = r_out_data;
  assign out_data_wr   = r_out_wr;
  assign out_valid     = r_out_valid;
  assign out_phv       = r_out_phv;
  assign out_phv_wr    = r_out_phv_wr;
  assign sent_pkt_cnt  = r_pkt;
  assign sent_byte_cnt = r_byte;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err_no_tail   = r_err;

endmodule

// File: tb/tb_pgm_rd_mt.sv
// tb_pgm_rd_mt: randomized self-checking bench for pgm_rd_mt.
// Packet-level reference model predicts emitted words and counters.
module tb_pgm_rd_mt;
  localparam int SW   = 3;
  localparam int SEGN = 8;
  localparam int PW   = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [133:0]  in_data = '0;
  logic          in_data_wr = 1'b0;
  logic [PW-1:0] in_phv = '0;
  logic          in_phv_wr = 1'b0;
  logic          in_alf = 1'b0;
  logic [133:0]  out_data;
  logic          out_data_wr, out_valid;
  logic [PW-1:0] out_phv;
  logic          out_phv_wr;
  logic          ram_rd;
  logic [4:0]    ram_addr;
  logic [133:0]  ram_rdata = '0;
  logic          cfg_bypass = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [2:0]    cfg_tpl_mask = '0;
  logic [31:0]   cfg_gap = '0;
  logic [31:0]   cfg_probe_every = '0;
  logic [63:0]   cfg_pkt_limit = '0;
  logic [63:0]   sent_pkt_cnt, sent_byte_cnt;
  logic          busy, done, err_no_tail;

  pgm_rd_mt #(.NUM_TPL(4), .SEG_W(SW), .PHV_W(PW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_data_wr(in_data_wr),
    .in_phv(in_phv), .in_phv_wr(in_phv_wr), .in_alf(in_alf),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_valid(out_valid), .out_phv(out_phv),
    .out_phv_wr(out_phv_wr),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .cfg_bypass(cfg_bypass), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .cfg_tpl_mask(cfg_tpl_mask),
    .cfg_gap(cfg_gap), .cfg_probe_every(cfg_probe_every),
    .cfg_pkt_limit(cfg_pkt_limit),
    .sent_pkt_cnt(sent_pkt_cnt), .sent_byte_cnt(sent_byte_cnt),
    .busy(busy), .done(done), .err_no_tail(err_no_tail)
  );

  always #5 clk = ~clk;

  logic [133:0] mem [0:31];
  always @(posedge clk) if (ram_rd) ram_rdata <= mem[ram_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [133:0] got,
                       input logic [133:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [133:0]  d;
    logic          pw;
    logic [PW-1:0] phv;
  } exp_t;
  exp_t q[$];
  exp_t m_e;

  longint cyc = 0, head_cyc = 0, tail_cyc = 0;
  int last_idle = -1, last_span = -1, n_out = 0;

  always @(negedge clk) begin
    cyc++;
    if (out_data_wr) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        m_e = q.pop_front();
        check("word", out_data, m_e.d);
        check("phv_wr", out_phv_wr, m_e.pw);
        if (m_e.pw) check("phv", out_phv, m_e.phv);
        check("valid", out_valid, m_e.d[133:132] == 2'b10);
      end
      if (out_data[133:132] == 2'b01) begin
        last_idle = int'(cyc - tail_cyc - 1);
        head_cyc  = cyc;
      end
      if (out_data[133:132] == 2'b10) begin
        last_span = int'(cyc - head_cyc);
        tail_cyc  = cyc;
      end
    end
  end

  int m_ptr = 0;

  // Packet-level model: pick templates, expand words, sum counters.
  task automatic model_run(input logic [2:0] mask, input int pe,
                           input int lim, output longint pkts,
                           output longint bytes);
    int dsp = 0;
    int data = 0;
    int t;
    pkts  = 0;
    bytes = 0;
    while (1) begin
      if ((pe != 0 && dsp == pe) || mask == 0) begin
        t = 3;
      end else begin
        t = m_ptr;
        while (!mask[t]) t = (t + 1) % 3;
        m_ptr = (t + 1) % 3;
      end
      for (int i = 0; i < SEGN; i++) begin
        exp_t e;
        logic [133:0] w;
        bit last;
        w = mem[t*SEGN+i];
        last = (w[133:132] == 2'b10) || (i == SEGN - 1);
        if (last) w[133:132] = 2'b10;
        e.d = w;
        e.pw = (w[133:132] == 2'b01);
        e.phv = '0;
        q.push_back(e);
        bytes += last ? (16 - int'(w[131:128])) : 16;
        if (last) break;
      end
      pkts++;
      if (t != 3) begin
        data++;
        dsp++;
      end else begin
        dsp = 0;
      end
      if (lim != 0 && data == lim) break;
    end
  endtask

  task automatic mk_tpl(input int t, input int len, input bit notail);
    for (int i = 0; i < SEGN; i++) begin
      logic [133:0] w;
      w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      w[131:128] = 4'($urandom_range(0, 15));
      if (i == 0) w[133:132] = 2'b01;
      else if (!notail && i == len - 1) w[133:132] = 2'b10;
      else w[133:132] = 2'b11;
      if (notail && i == SEGN - 1) w[131:128] = 4'd0;
      mem[t*SEGN+i] = w;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    q.delete();
    m_ptr = 0;
  endtask

  task automatic pulse_start;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int c = 0;
    while (!done && c < maxc) begin
      tick(1);
      c++;
    end
    check("done", done, 1);
    tick(1);
    check("q_empty", q.size(), 0);
  endtask

  task automatic wait_words(input int n0, input int k);
    int c = 0;
    while (n_out < n0 + k && c < 100) begin
      tick(1);
      c++;
    end
    check("words_seen", n_out >= n0 + k, 1);
  endtask

  task automatic set_cfg(input logic [2:0] m, input int pe,
                         input int lim, input int g);
    cfg_tpl_mask    = m;
    cfg_probe_every = pe;
    cfg_pkt_limit   = lim;
    cfg_gap         = g;
  endtask

  longint pk, by;
  int n0;

  initial begin
    for (int t = 0; t < 4; t++) mk_tpl(t, 4, 0);
    do_reset;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkt", sent_pkt_cnt, 0);
    check("rst_byte", sent_byte_cnt, 0);
    check("rst_wr", out_data_wr, 0);
    check("rst_err", err_no_tail, 0);

    // reset mid-EMIT, then replay from word 0
    mk_tpl(0, 6, 0);
    set_cfg(3'b001, 0, 1, 0);
    model_run(3'b001, 0, 1, pk, by);
    n0 = n_out;
    pulse_start;
    wait_words(n0, 2);
    rst = 1'b1;
    tick(1);
    check("rst_mid_wr", out_data_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_pkt", sent_pkt_cnt, 0);
    rst = 1'b0;
    q.delete();
    m_ptr = 0;
    tick(1);
    model_run(3'b001, 0, 1, pk, by);
    pulse_start;
    wait_done(100);
    check("replay_pkt", sent_pkt_cnt, pk);
    check("replay_byte", sent_byte_cnt, by);

    // two templates round-robin
    do_reset;
    mk_tpl(0, 3, 0);
    mk_tpl(1, 5, 0);
    set_cfg(3'b011, 0, 4, 0);
    model_run(3'b011, 0, 4, pk, by);
    pulse_start;
    wait_done(200);
    check("rr_pkt", sent_pkt_cnt, 4);
    check("rr_byte", sent_byte_cnt, by);
    check("rr_busy", busy, 0);

    // probe insertion D,D,P,D,D
    do_reset;
    mk_tpl(0, 3, 0);
    mk_tpl(3, 4, 0);
    set_cfg(3'b001, 2, 4, 0);
    model_run(3'b001, 2, 4, pk, by);
    pulse_start;
    wait_done(300);
    check("probe_pkt", sent_pkt_cnt, 5);
    check("probe_byte", sent_byte_cnt, by);

    // inter-packet gap
    do_reset;
    mk_tpl(0, 4, 0);
    set_cfg(3'b001, 0, 2, 10);
    model_run(3'b001, 0, 2, pk, by);
    pulse_start;
    wait_done(300);
    check("gap_idle", last_idle, 10);
    check("gap_pkt", sent_pkt_cnt, 2);

    // almost-full before head, ignored mid-packet
    do_reset;
    set_cfg(3'b001, 0, 1, 0);
    model_run(3'b001, 0, 1, pk, by);
    in_alf = 1'b1;
    n0 = n_out;
    pulse_start;
    tick(20);
    check("alf_hold", n_out - n0, 0);
    in_alf = 1'b0;
    wait_words(n0, 1);
    in_alf = 1'b1;
    wait_done(100);
    check("alf_span", last_span, 3);
    in_alf = 1'b0;

    // segment without a tail
    do_reset;
    mk_tpl(2, 0, 1);
    set_cfg(3'b100, 0, 1, 0);
    model_run(3'b100, 0, 1, pk, by);
    pulse_start;
    wait_done(100);
    check("notail_err", err_no_tail, 1);
    check("notail_pkt", sent_pkt_cnt, 1);
    check("notail_byte", sent_byte_cnt, 128);

    // stop mid-packet, then start+stop together
    do_reset;
    mk_tpl(0, 6, 0);
    set_cfg(3'b001, 0, 0, 0);
    model_run(3'b001, 0, 1, pk, by);
    n0 = n_out;
    pulse_start;
    wait_words(n0, 1);
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
    wait_done(100);
    check("stop_pkt", sent_pkt_cnt, 1);
    cfg_start = 1'b1;
    cfg_stop  = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    tick(3);
    check("startstop_busy", busy, 0);
    check("startstop_done", done, 1);

    // bypass pass-through, mode dropped mid-packet
    do_reset;
    cfg_bypass = 1'b1;
    tick(2);
    check("byp_enter", busy, 1);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      logic [133:0] w;
      w[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      w[131:128] = (i == 3) ? 4'($urandom_range(0, 15)) : 4'd0;
      w[133:132] = (i == 0) ? 2'b01 : (i == 3) ? 2'b10 : 2'b11;
      e.d   = w;
      e.pw  = (i == 0);
      e.phv = {$urandom, $urandom};
      q.push_back(e);
      in_data    = w;
      in_data_wr = 1'b1;
      in_phv_wr  = (i == 0);
      in_phv     = e.phv;
      if (i == 2) cfg_bypass = 1'b0;
      tick(1);
      check("byp_lat", out_data_wr, 1);
      check("byp_busy", busy, i < 3);
    end
    in_data_wr = 1'b0;
    in_phv_wr  = 1'b0;
    tick(2);
    check("byp_q_empty", q.size(), 0);

    // randomized configurations
    for (int r = 0; r < 4; r++) begin
      logic [2:0] m;
      int pe, lim, g;
      do_reset;
      for (int t = 0; t < 4; t++) mk_tpl(t, $urandom_range(2, 7), 0);
      m   = 3'($urandom_range(1, 7));
      pe  = $urandom_range(0, 3);
      lim = $urandom_range(1, 6);
      g   = $urandom_range(0, 3);
      set_cfg(m, pe, lim, g);
      model_run(m, pe, lim, pk, by);
      pulse_start;
      wait_done(2000);
      check("rnd_pkt", sent_pkt_cnt, pk);
      check("rnd_byte", sent_byte_cnt, by);
      check("rnd_err", err_no_tail, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
